pb_io_router: RTL and testbench

//  Parametrised PicoBlaze port decoder and interrupt aggregator; successor to the hand-coded per-port decode in our top levels.

---
 rtl/pb_io_router.sv | 129 ++++++++++++
 tb/tb_pb_io_router.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_io_router.sv
// PicoBlaze port decoder: registered read mux, read-ack/write-enable pulses,
// plus an edge-latched, maskable interrupt controller with in-service handshake.
module pb_io_router #(
  parameter int          NUM_IN        = 4,
  parameter int          NUM_OUT       = 4,
  parameter int          NUM_IRQ       = 4,
  parameter logic [7:0]  IN_BASE       = 8'h00,
  parameter logic [7:0]  OUT_BASE      = 8'h10,
  parameter logic [7:0]  IRQ_PEND_PORT = 8'hF0,
  parameter logic [7:0]  IRQ_MASK_PORT = 8'hF1,
  parameter logic [7:0]  IRQ_CLR_PORT  = 8'hF2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            pb_port_id,
  input  logic                  pb_read_strobe,
  input  logic                  pb_write_strobe,
  input  logic [7:0]            pb_out_port,
  output logic [7:0]            pb_in_port,
  output logic                  pb_interrupt,
  input  logic                  pb_int_ack,
  input  logic [NUM_IN*8-1:0]   in_data,
  output logic [NUM_IN-1:0]     rd_ack,
  output logic [7:0]            out_data,
  output logic [NUM_OUT-1:0]    wr_en,
  input  logic [NUM_IRQ-1:0]    irq_src,
  output logic [1:0]            irq_state
);

  // Bus handshake: PicoBlaze strobes are single-cycle qualifiers; rd_ack and
  // wr_en answer each strobe with exactly one pulse one cycle later.
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SERVICE = 2'd2} state_t;

  state_t               state;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   pending;
  logic [NUM_IRQ-1:0]   prev;

  logic [7:0]           rd_sel;
  logic [NUM_IN-1:0]    ack_nxt;
  logic [NUM_OUT-1:0]   wen_nxt;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   clr;
  logic [NUM_IRQ-1:0]   pend_nxt;
  logic                 clr_hit;
  logic                 mask_hit;
  logic                 active;

  // IRQ register ports are decoded last so they override any overlapping input device.
  always_comb begin
    rd_sel  = '0;
    ack_nxt = '0;
    wen_nxt = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (pb_port_id == 8'(IN_BASE + k)) begin
        rd_sel     = in_data[k*8 +: 8];
        ack_nxt[k] = pb_read_strobe;
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (pb_port_id == 8'(OUT_BASE + k)) wen_nxt[k] = pb_write_strobe;
    end
    if (pb_port_id == IRQ_PEND_PORT)      rd_sel = 8'(pending);
    else if (pb_port_id == IRQ_MASK_PORT) rd_sel = 8'(mask);
  end

  assign clr_hit   = pb_write_strobe & (pb_port_id == IRQ_CLR_PORT);
  assign mask_hit  = pb_write_strobe & (pb_port_id == IRQ_MASK_PORT);
  assign clr       = clr_hit ? pb_out_port[NUM_IRQ-1:0] : '0;
  assign rise      = irq_src & ~prev;
  assign pend_nxt  = (pending & ~clr) | rise;
  assign active    = |(pending & mask);
  assign irq_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_in_port <= '0;
      rd_ack     <= '0;
      out_data   <= '0;
      wr_en      <= '0;
      mask       <= '0;
      pending    <= '0;
      prev       <= '0;
    end else begin
      pb_in_port <= rd_sel;
      rd_ack     <= ack_nxt;
      wr_en      <= wen_nxt;
      if (|wen_nxt) out_data <= pb_out_port;
      if (mask_hit) mask <= pb_out_port[NUM_IRQ-1:0];
      pending    <= pend_nxt;
      prev       <= irq_src;
    end
  end

  // Interrupt sequencing; pb_interrupt is high exactly while ARMED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pb_interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            state        <= ARMED;
            pb_interrupt <= 1'b1;
          end
        end
        ARMED: begin
          if (pb_int_ack) begin
            state        <= SERVICE;
            pb_interrupt <= 1'b0;
          end else if (!active) begin
            state        <= IDLE;
            pb_interrupt <= 1'b0;
          end
        end
        SERVICE: begin
          pb_interrupt <= 1'b0;
          if (clr_hit) state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          pb_interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_io_router.sv
// Bench for pb_io_router: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pb_io_router;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int NUM_IRQ = 4;
  localparam logic [7:0] P_PEND = 8'hF0;
  localparam logic [7:0] P_MASK = 8'hF1;
  localparam logic [7:0] P_CLR  = 8'hF2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  port_id;
  logic        rs;
  logic        ws;
  logic [7:0]  out_port;
  logic [7:0]  pb_in_port;
  logic        pb_interrupt;
  logic        ack;
  logic [31:0] in_data;
  logic [3:0]  rd_ack;
  logic [7:0]  out_data;
  logic [3:0]  wr_en;
  logic [3:0]  irq_src;
  logic [1:0]  irq_state;

  int checks = 0;
  int failures = 0;

  pb_io_router dut (
    .clk(clk), .reset(rst_n), .pb_port_id(port_id), .pb_read_strobe(rs),
    .pb_write_strobe(ws), .pb_out_port(out_port), .pb_in_port(pb_in_port),
    .pb_interrupt(pb_interrupt), .pb_int_ack(ack), .in_data(in_data),
    .rd_ack(rd_ack), .out_data(out_data), .wr_en(wr_en), .irq_src(irq_src),
    .irq_state(irq_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: outputs expected after each edge, packed into a queue
  logic [24:0] exp_q[$];
  logic [7:0]  m_in_port, m_out_data;
  logic [3:0]  m_rd_ack, m_wr_en, m_pend, m_mask, m_prev;
  logic        m_int;
  int          m_mode;  // 0 waiting, 1 interrupt raised, 2 handler running

  initial begin
    m_in_port = 0; m_out_data = 0; m_rd_ack = 0; m_wr_en = 0;
    m_pend = 0; m_mask = 0; m_prev = 0; m_int = 0; m_mode = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_in_port = 0; m_out_data = 0; m_rd_ack = 0; m_wr_en = 0;
        m_pend = 0; m_mask = 0; m_prev = 0; m_int = 0; m_mode = 0;
      end else begin
        int in_off, out_off;
        logic [3:0] rise, clr;
        logic any_en, clr_wr;
        in_off  = int'(port_id) - 0;
        out_off = int'(port_id) - 16;
        any_en  = (m_pend & m_mask) != 0;
        clr_wr  = ws && (port_id == P_CLR);
        rise    = irq_src & ~m_prev;
        clr     = clr_wr ? out_port[3:0] : 4'h0;
        if (port_id == P_PEND)      m_in_port = {4'h0, m_pend};
        else if (port_id == P_MASK) m_in_port = {4'h0, m_mask};
        else if (in_off >= 0 && in_off < NUM_IN) m_in_port = in_data[in_off*8 +: 8];
        else m_in_port = 8'h00;
        m_rd_ack = (rs && in_off >= 0 && in_off < NUM_IN) ? 4'(1 << in_off) : 4'h0;
        if (ws && out_off >= 0 && out_off < NUM_OUT) begin
          m_out_data = out_port;
          m_wr_en    = 4'(1 << out_off);
        end else begin
          m_wr_en = 4'h0;
        end
        if (m_mode == 2)      m_mode = clr_wr ? 0 : 2;
        else if (m_mode == 1) m_mode = ack ? 2 : (any_en ? 1 : 0);
        else                  m_mode = any_en ? 1 : 0;
        m_int  = (m_mode == 1);
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq_src;
        if (ws && port_id == P_MASK) m_mask = out_port[3:0];
      end
      exp_q.push_back({m_in_port, m_rd_ack, m_out_data, m_wr_en, m_int});
    end
  end

  // scoreboard: compare DUT against model every cycle, away from the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_queue got=empty exp=entry at %0t", $time);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("sb_in_port",  32'(pb_in_port),   32'(e[24:17]));
        check("sb_rd_ack",   32'(rd_ack),       32'(e[16:13]));
        check("sb_out_data", 32'(out_data),     32'(e[12:5]));
        check("sb_wr_en",    32'(wr_en),        32'(e[4:1]));
        check("sb_int",      32'(pb_interrupt), 32'(e[0]));
      end
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pb_read(input logic [7:0] p);
    @(negedge clk); port_id = p; rs = 1'b1;
    @(negedge clk); rs = 1'b0;
  endtask

  task automatic pb_write(input logic [7:0] p, input logic [7:0] d);
    @(negedge clk); port_id = p; out_port = d; ws = 1'b1;
    @(negedge clk); ws = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] b);
    @(negedge clk); irq_src = b;
    @(negedge clk); irq_src = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; port_id = 8'h10; rs = 1'b1; ws = 1'b1; out_port = 8'hFF;
    ack = 1'b1; irq_src = 4'hF; in_data = 32'hDEADBEEF;

    // T1: reset held with activity, then released
    idle(4);
    check("t1_rst_in_port", 32'(pb_in_port), 0);
    check("t1_rst_wr_en", 32'(wr_en), 0);
    check("t1_rst_int", 32'(pb_interrupt), 0);
    rst_n = 1'b1; rs = 1'b0; ws = 1'b0; ack = 1'b0; port_id = 8'h40;
    idle(3);
    check("t1_post_out_data", 32'(out_data), 0);
    check("t1_post_int", 32'(pb_interrupt), 0);
    check("t1_post_rd_ack", 32'(rd_ack), 0);
    irq_src = 4'h0;
    pb_write(P_CLR, 8'hFF);

    // T2: read map
    in_data = 32'h11A5_2233;
    pb_read(8'h02);
    check("t2_in_port", 32'(pb_in_port), 32'hA5);
    check("t2_rd_ack", 32'(rd_ack), 32'b0100);
    idle(1);
    check("t2_rd_ack_once", 32'(rd_ack), 0);
    pb_read(8'h40);
    check("t2_unmapped_data", 32'(pb_in_port), 0);
    check("t2_unmapped_ack", 32'(rd_ack), 0);

    // T3: write map
    pb_write(8'h13, 8'h3C);
    check("t3_out_data", 32'(out_data), 32'h3C);
    check("t3_wr_en", 32'(wr_en), 32'b1000);
    idle(1);
    check("t3_wr_en_once", 32'(wr_en), 0);
    pb_write(8'h20, 8'h77);
    check("t3_unmapped_wr_en", 32'(wr_en), 0);
    check("t3_hold_data", 32'(out_data), 32'h3C);

    // T4: interrupt flow
    pb_write(P_MASK, 8'h02);
    pulse_irq(4'b0010);
    idle(1);
    check("t4_int_raised", 32'(pb_interrupt), 1);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    check("t4_int_acked", 32'(pb_interrupt), 0);
    pb_read(P_PEND);
    check("t4_pending", 32'(pb_in_port), 32'h02);
    pb_write(P_CLR, 8'h02);
    idle(3);
    check("t4_int_after_clr", 32'(pb_interrupt), 0);
    pb_read(P_PEND);
    check("t4_pending_clr", 32'(pb_in_port), 0);

    // T5: masking and set-vs-clear collision
    pb_write(P_MASK, 8'h00);
    pulse_irq(4'b0001);
    idle(3);
    check("t5_masked", 32'(pb_interrupt), 0);
    pb_write(P_MASK, 8'h01);
    idle(1);
    check("t5_unmasked", 32'(pb_interrupt), 1);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk); irq_src = 4'b0001; port_id = P_CLR; out_port = 8'h01; ws = 1'b1;
    @(negedge clk); ws = 1'b0; irq_src = 4'h0;
    pb_read(P_PEND);
    check("t5_set_wins", 32'(pb_in_port), 32'h01);
    check("t5_rearmed", 32'(pb_interrupt), 1);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    pb_write(P_CLR, 8'h0F);

    // T6: reset while ARMED, then while wr_en is high
    pulse_irq(4'b0001);
    idle(1);
    check("t6_armed", 32'(pb_interrupt), 1);
    #2 rst_n = 1'b0;
    #1 check("t6_int_async", 32'(pb_interrupt), 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("t6_no_int_after", 32'(pb_interrupt), 0);
    pb_read(P_MASK);
    check("t6_mask_cleared", 32'(pb_in_port), 0);
    @(negedge clk); port_id = 8'h11; out_port = 8'h5A; ws = 1'b1;
    @(posedge clk); #3;
    check("t6_wr_en_live", 32'(wr_en), 32'b0010);
    rst_n = 1'b0;
    #1 check("t6_wr_en_async", 32'(wr_en), 0);
    check("t6_out_data_async", 32'(out_data), 0);
    @(negedge clk); ws = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("t6_no_pulse_after", 32'(wr_en), 0);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      int sel, st;
      @(negedge clk);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    port_id = 8'($urandom_range(0, 3));
        2, 3:    port_id = 8'(8'h10 + $urandom_range(0, 3));
        4:       port_id = P_PEND;
        5:       port_id = P_MASK;
        6:       port_id = P_CLR;
        default: port_id = 8'($urandom_range(0, 255));
      endcase
      st = $urandom_range(0, 3);
      rs = (st == 1);
      ws = (st == 2);
      out_port = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 5) == 0);
      in_data = $urandom;
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom_range(0, 15));
    end
    @(negedge clk); rs = 1'b0; ws = 1'b0; ack = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
